// File: rtl/mlogic_pkg.sv
// Shared types for the MiniMachines bitwise logic / reduction stage.
// Op encoding, decode constants and per-op identity values.
package mlogic_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_PASS = 3'd6,
        OP_NOT  = 3'd7
    } op_e;

    localparam op_e OP_FIRST = OP_AND;
    localparam op_e OP_LAST  = OP_NOT;

    // Ops whose result is the complement of a simpler base op.
    function automatic logic op_is_inverting(input op_e op);
        return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR) || (op == OP_NOT);
    endfunction

    // Bit value e with f(a, e) == a for every bit; ops without an identity return 0.
    function automatic logic op_identity_bit(input op_e op);
        logic id;
        case (op)
            OP_AND:  id = 1'b1;
            OP_XNOR: id = 1'b1;
            default: id = 1'b0;
        endcase
        return id;
    endfunction

endpackage

// File: rtl/mlogic_core.sv
// Purely combinational BIT_WIDTH-wide bitwise function y = f(a, b, op).
module mlogic_core
    import mlogic_pkg::*;
#(
    parameter int BIT_WIDTH = 8
) (
    input  logic [BIT_WIDTH-1:0] a_i,
    input  logic [BIT_WIDTH-1:0] b_i,
    input  op_e                  op_i,
    output logic [BIT_WIDTH-1:0] y_o
);

    logic [BIT_WIDTH-1:0] base;

    // Inverting ops share the datapath of their base op plus a final complement.
    always_comb begin
        base = '0;
        case (op_i)
            OP_AND,  OP_NAND: base = a_i & b_i;
            OP_OR,   OP_NOR:  base = a_i | b_i;
            OP_XOR,  OP_XNOR: base = a_i ^ b_i;
            OP_PASS, OP_NOT:  base = a_i;
            default:          base = a_i;
        endcase
        y_o = op_is_inverting(op_i) ? ~base : base;
    end

endmodule

// File: rtl/mlogic_acc.sv
// Bitwise logic unit with stream-accumulate mode, registered valid/ready output
// and a saturating count of beats folded since the last seed.
module mlogic_acc
    import mlogic_pkg::*;
#(
    parameter int BIT_WIDTH   = 8,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BIT_WIDTH-1:0]   Input_1,
    input  logic [BIT_WIDTH-1:0]   Input_2,
    input  logic [2:0]             Op,
    input  logic                   Acc_en,
    input  logic                   Clear,
    input  logic                   In_valid,
    output logic                   In_ready,
    output logic [BIT_WIDTH-1:0]   Output,
    output logic                   Out_valid,
    input  logic                   Out_ready,
    output logic                   Zero,
    output logic [COUNT_WIDTH-1:0] Count
);

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    logic [BIT_WIDTH-1:0]   out_q, out_d;
    logic [BIT_WIDTH-1:0]   acc_q, acc_d;
    logic                   vld_q, vld_d;
    logic                   zero_q, zero_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                   accept;
    logic [BIT_WIDTH-1:0]   core_a, core_b, core_y;

    assign In_ready = !vld_q || Out_ready;
    assign accept   = In_valid && In_ready;

    // In accumulate mode Input_1 becomes operand b so Input_2 never reaches state.
    assign core_a = Acc_en ? acc_q   : Input_1;
    assign core_b = Acc_en ? Input_1 : Input_2;

    mlogic_core #(
        .BIT_WIDTH(BIT_WIDTH)
    ) u_core (
        .a_i (core_a),
        .b_i (core_b),
        .op_i(op_e'(Op)),
        .y_o (core_y)
    );

    always_comb begin
        out_d = out_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        vld_d = vld_q;
        if (accept) begin
            vld_d = 1'b1;
            if (!Acc_en) begin
                out_d = core_y;
            end else if (Clear) begin
                acc_d = Input_1;
                out_d = Input_1;
                cnt_d = CNT_ONE;
            end else begin
                acc_d = core_y;
                out_d = core_y;
                cnt_d = sat_inc(cnt_q);
            end
        end else if (vld_q && Out_ready) begin
            vld_d = 1'b0;
        end
        zero_d = (out_d == '0);
    end

    // Output register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            acc_q  <= '0;
            vld_q  <= 1'b0;
            zero_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            out_q  <= out_d;
            acc_q  <= acc_d;
            vld_q  <= vld_d;
            zero_q <= zero_d;
            cnt_q  <= cnt_d;
        end
    end

    assign Output    = out_q;
    assign Out_valid = vld_q;
    assign Zero      = zero_q;
    assign Count     = cnt_q;

endmodule

// File: tb/tb_mlogic_acc.sv
// Directed plus randomized bench for mlogic_acc, two instances (COUNT_WIDTH 8 and 2)
// sharing stimulus and checked against a behavioural model.
module tb_mlogic_acc;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in1, in2;
    logic [2:0] op;
    logic       acc_en, clr, in_valid, out_ready;

    logic       rdy8, vld8, zero8, rdy2, vld2, zero2;
    logic [7:0] out8, out2, cnt8;
    logic [1:0] cnt2;

    int n_vec = 0;
    int n_err = 0;

    // model state
    logic [7:0] m_out, m_acc;
    logic       m_vld;
    int         m_cnt8, m_cnt2;

    always #5 clk = ~clk;

    mlogic_acc #(.BIT_WIDTH(8), .COUNT_WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .Input_1(in1), .Input_2(in2), .Op(op),
        .Acc_en(acc_en), .Clear(clr), .In_valid(in_valid), .In_ready(rdy8),
        .Output(out8), .Out_valid(vld8), .Out_ready(out_ready), .Zero(zero8), .Count(cnt8)
    );

    mlogic_acc #(.BIT_WIDTH(8), .COUNT_WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .Input_1(in1), .Input_2(in2), .Op(op),
        .Acc_en(acc_en), .Clear(clr), .In_valid(in_valid), .In_ready(rdy2),
        .Output(out2), .Out_valid(vld2), .Out_ready(out_ready), .Zero(zero2), .Count(cnt2)
    );

    function automatic logic [7:0] f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o);
        case (o)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return ~(a ^ b);
            3'd6:    return a;
            default: return ~a;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, check ready before the rising edge,
    // advance the model at the rising edge, check registered outputs at the next falling edge.
    task automatic step(input logic r, input logic iv, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] o, input logic ae, input logic cl, input logic ordy);
        logic take;
        rst = r; in_valid = iv; in1 = a; in2 = b; op = o; acc_en = ae; clr = cl; out_ready = ordy;
        #1;
        check("in_ready8", 32'(rdy8), 32'(!m_vld || ordy));
        check("in_ready2", 32'(rdy2), 32'(!m_vld || ordy));
        take = iv && (!m_vld || ordy);
        @(posedge clk);
        if (r) begin
            m_out = 8'h00; m_acc = 8'h00; m_vld = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
        end else if (take) begin
            m_vld = 1'b1;
            if (!ae) begin
                m_out = f(a, b, o);
            end else if (cl) begin
                m_acc = a; m_out = a; m_cnt8 = 1; m_cnt2 = 1;
            end else begin
                m_acc = f(m_acc, a, o); m_out = m_acc;
                m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
                m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
            end
        end else if (ordy) begin
            m_vld = 1'b0;
        end
        @(negedge clk);
        check("output8", 32'(out8), 32'(m_out));
        check("output2", 32'(out2), 32'(m_out));
        check("out_valid8", 32'(vld8), 32'(m_vld));
        check("out_valid2", 32'(vld2), 32'(m_vld));
        check("zero8", 32'(zero8), 32'(m_out == 8'h00));
        check("zero2", 32'(zero2), 32'(m_out == 8'h00));
        check("count8", 32'(cnt8), 32'(m_cnt8));
        check("count2", 32'(cnt2), 32'(m_cnt2));
    endtask

    logic [7:0] exp_ops [8] = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'hF0, 8'h0F};
    logic [7:0] and_in  [3] = '{8'hF0, 8'h3C, 8'h0F};
    logic [7:0] and_out [3] = '{8'hF0, 8'h30, 8'h00};

    initial begin
        m_out = 8'h00; m_acc = 8'h00; m_vld = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
        rst = 1'b1; in_valid = 1'b0; in1 = '0; in2 = '0; op = '0;
        acc_en = 1'b0; clr = 1'b0; out_ready = 1'b1;
        @(negedge clk);

        // reset state
        step(1, 0, 8'h00, 8'h00, 3'd0, 0, 0, 1);
        check("rst_output", 32'(out8), 32'h0);
        check("rst_zero", 32'(zero8), 32'h1);
        check("rst_valid", 32'(vld8), 32'h0);

        // all eight ops, non-accumulate
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 8'hF0, 8'h3C, 3'(i), 0, 0, 1);
            check($sformatf("op%0d_output", i), 32'(out8), 32'(exp_ops[i]));
            check($sformatf("op%0d_zero", i), 32'(zero8), 32'h0);
        end

        // seed then AND-fold
        step(0, 1, 8'hFF, 8'h00, 3'd0, 1, 1, 1);
        check("seed_output", 32'(out8), 32'hFF);
        check("seed_count", 32'(cnt8), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, and_in[i], 8'h00, 3'd0, 1, 0, 1);
            check($sformatf("and%0d_output", i), 32'(out8), 32'(and_out[i]));
            check($sformatf("and%0d_count", i), 32'(cnt8), 32'(i + 2));
        end
        check("and_last_zero", 32'(zero8), 32'h1);

        // saturation of the 2-bit counter
        step(0, 1, 8'h11, 8'h00, 3'd1, 1, 1, 1);
        check("sat_seed_count2", 32'(cnt2), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 8'h00, 8'h00, 3'd1, 1, 0, 1);
            check($sformatf("sat%0d_count2", i), 32'(cnt2), 32'((i + 2 > 3) ? 3 : i + 2));
        end
        check("sat_count8", 32'(cnt8), 32'd6);

        // backpressure
        step(0, 0, 8'h00, 8'h00, 3'd0, 0, 0, 1);
        step(0, 1, 8'h55, 8'h0F, 3'd0, 0, 0, 0);
        check("bp_first_output", 32'(out8), 32'h05);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 8'hAA, 8'h01, 3'd1, 0, 0, 0);
            check($sformatf("bp%0d_hold", i), 32'(out8), 32'h05);
            check($sformatf("bp%0d_ready", i), 32'(rdy8), 32'h0);
        end
        step(0, 1, 8'hAA, 8'h01, 3'd1, 0, 0, 1);
        check("bp_release_output", 32'(out8), 32'hAB);
        check("bp_release_valid", 32'(vld8), 32'h1);

        // Clear without Acc_en leaves acc/count alone
        step(0, 1, 8'h30, 8'h00, 3'd0, 1, 1, 1);
        step(0, 1, 8'h01, 8'h02, 3'd1, 0, 1, 1);
        check("clr_noacc_output", 32'(out8), 32'h03);
        check("clr_noacc_count", 32'(cnt8), 32'd1);
        step(0, 1, 8'h80, 8'hFF, 3'd1, 1, 0, 1);
        check("clr_noacc_fold", 32'(out8), 32'hB0);
        check("clr_noacc_fold_count", 32'(cnt8), 32'd2);

        // reset mid-stream drops the offered beat
        step(1, 1, 8'hFF, 8'hFF, 3'd1, 0, 0, 1);
        check("midrst_output", 32'(out8), 32'h0);
        check("midrst_valid", 32'(vld8), 32'h0);
        check("midrst_count", 32'(cnt8), 32'h0);
        check("midrst_zero", 32'(zero8), 32'h1);
        step(0, 0, 8'hFF, 8'hFF, 3'd1, 0, 0, 1);
        check("midrst_after_valid", 32'(vld8), 32'h0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                 8'($urandom), 8'($urandom), 3'($urandom),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
